// File: rtl/spi_rx_ctrl_if.sv
// Bus bundle between the SPI receive front end and its environment.
// The slave modport is the receive controller; master is whoever drives SS_n/MOSI.
interface spi_rx_ctrl_if #(
  parameter int FRAME_W = 10
);
  logic               SS_n;
  logic               MOSI;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic               tx_en;
  logic               rd_addr_seen;

  modport master (
    output SS_n, MOSI,
    input  rx_data, rx_valid, tx_en, rd_addr_seen
  );

  modport slave (
    input  SS_n, MOSI,
    output rx_data, rx_valid, tx_en, rd_addr_seen
  );
endinterface

// File: rtl/spi_rx_ctrl.sv
// SPI slave receive FSM: deserialises 10-bit command frames MSB first and
// tracks the read-address / read-data pairing that opens the MISO window.
module spi_rx_ctrl #(
  parameter int FRAME_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_rx_ctrl_if.slave bus
);
  localparam int CW = $clog2(FRAME_W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_W - 1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_END
  } state_t;

  state_t             r_state, w_state_next;
  logic [CW-1:0]      r_cnt, w_cnt_next;
  logic [FRAME_W-1:0] r_shift, w_shift_next;
  logic [FRAME_W-1:0] r_rx_data, w_rx_data_next;
  logic               r_rx_valid, w_rx_valid_next;
  logic               r_tx_en, w_tx_en_next;
  logic               r_rd_addr_seen, w_rd_addr_seen_next;
  logic [FRAME_W-1:0] w_frame;

  // Shift register with the current MOSI bit appended: the full frame on the last bit.
  assign w_frame = {r_shift[FRAME_W-2:0], bus.MOSI};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_shift        <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_tx_en        <= 1'b0;
      r_rd_addr_seen <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_shift        <= w_shift_next;
      r_rx_data      <= w_rx_data_next;
      r_rx_valid     <= w_rx_valid_next;
      r_tx_en        <= w_tx_en_next;
      r_rd_addr_seen <= w_rd_addr_seen_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_cnt_next          = r_cnt;
    w_shift_next        = r_shift;
    w_rx_data_next      = r_rx_data;
    w_rx_valid_next     = 1'b0;
    w_tx_en_next        = r_tx_en;
    w_rd_addr_seen_next = r_rd_addr_seen;

    // Deselect aborts whatever is in flight, including a frame on its last bit.
    if (bus.SS_n && (r_state != IDLE)) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
      w_shift_next = '0;
      w_tx_en_next = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!bus.SS_n) w_state_next = CHK_CMD;
        end
        CHK_CMD: begin
          w_shift_next = {{(FRAME_W-1){1'b0}}, bus.MOSI};
          w_cnt_next   = CW'(1);
          if (!bus.MOSI)          w_state_next = WRITE;
          else if (r_rd_addr_seen) w_state_next = READ_DATA;
          else                    w_state_next = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          w_shift_next = w_frame;
          if (r_cnt == LAST_CNT) begin
            w_rx_data_next  = w_frame;
            w_rx_valid_next = 1'b1;
            w_cnt_next      = '0;
            w_state_next    = WAIT_END;
            if (r_state == READ_ADD) w_rd_addr_seen_next = 1'b1;
            if (r_state == READ_DATA) begin
              w_rd_addr_seen_next = 1'b0;
              w_tx_en_next        = 1'b1;
            end
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        WAIT_END: begin
          w_state_next = WAIT_END;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  assign bus.rx_data      = r_rx_data;
  assign bus.rx_valid     = r_rx_valid;
  assign bus.tx_en        = r_tx_en;
  assign bus.rd_addr_seen = r_rd_addr_seen;
endmodule

// File: tb/tb_spi_rx_ctrl.sv
// Bench for spi_rx_ctrl: directed frame table, hand-written abort/reset
// sequences and random SS_n/MOSI traffic against a frame-level reference model.
module tb_spi_rx_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_rx_ctrl_if #(.FRAME_W(10)) bus ();

  spi_rx_ctrl #(.FRAME_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int pulse_acc = 0;

  // Reference model: a frame is the 10 MOSI bits taken on the edges after the
  // dead select edge; any deselect throws away collected bits.
  logic       m_active, m_done;
  logic       m_bits[$];
  logic [9:0] m_frame, m_rx_data;
  logic       m_rx_valid, m_tx_en, m_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_done = 1'b0; m_bits.delete();
      m_rx_data = '0; m_rx_valid = 1'b0; m_tx_en = 1'b0; m_rd = 1'b0;
    end else begin
      m_rx_valid = 1'b0;
      if (bus.SS_n) begin
        m_active = 1'b0; m_done = 1'b0; m_bits.delete(); m_tx_en = 1'b0;
      end else if (!m_active) begin
        m_active = 1'b1;
      end else if (!m_done) begin
        m_bits.push_back(bus.MOSI);
        if (m_bits.size() == 10) begin
          m_frame = '0;
          foreach (m_bits[k]) m_frame = {m_frame[8:0], m_bits[k]};
          m_rx_data  = m_frame;
          m_rx_valid = 1'b1;
          m_done     = 1'b1;
          m_bits.delete();
          if (m_frame[9]) begin
            if (m_rd) begin m_rd = 1'b0; m_tx_en = 1'b1; end
            else m_rd = 1'b1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock step: observe on the falling edge and compare against the model.
  task automatic tick();
    @(negedge clk);
    if (bus.rx_valid) pulse_acc++;
    if (rst_n) begin
      check("model_rx_data", 32'(bus.rx_data), 32'(m_rx_data));
      check("model_rx_valid", 32'(bus.rx_valid), 32'(m_rx_valid));
      check("model_tx_en", 32'(bus.tx_en), 32'(m_tx_en));
      check("model_rd_addr_seen", 32'(bus.rd_addr_seen), 32'(m_rd));
    end
  endtask

  task automatic send_frame(input logic [9:0] f, input int nbits, input int hold,
                            output logic tx_seen);
    pulse_acc = 0;
    bus.SS_n = 1'b0;
    bus.MOSI = 1'($urandom_range(0, 1));
    tick();
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = f[9-i];
      tick();
    end
    for (int h = 0; h < hold; h++) tick();
    tx_seen  = bus.tx_en;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'($urandom_range(0, 1));
    tick();
  endtask

  typedef struct {
    logic [9:0] frame;
    int         nbits;
    int         hold;
    logic [9:0] exp_data;
    int         exp_pulses;
    logic       exp_rd;
    logic       exp_tx;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic tx_seen;

    vecs[0] = '{10'h0A5, 10, 0, 10'h0A5, 1, 1'b0, 1'b0};
    vecs[1] = '{10'h13C, 10, 0, 10'h13C, 1, 1'b0, 1'b0};
    vecs[2] = '{10'h0FF, 10, 0, 10'h0FF, 1, 1'b0, 1'b0};
    vecs[3] = '{10'h207, 10, 0, 10'h207, 1, 1'b1, 1'b0};
    vecs[4] = '{10'h300, 10, 8, 10'h300, 1, 1'b0, 1'b1};
    vecs[5] = '{10'h1AA,  6, 0, 10'h300, 0, 1'b0, 1'b0};
    vecs[6] = '{10'h1AA, 10, 0, 10'h1AA, 1, 1'b0, 1'b0};
    vecs[7] = '{10'h300, 10, 0, 10'h300, 1, 1'b1, 1'b0};
    vecs[8] = '{10'h2FF, 10, 2, 10'h2FF, 1, 1'b0, 1'b1};

    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rx_data", 32'(bus.rx_data), 32'h0);
    check("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("reset_tx_en", 32'(bus.tx_en), 32'h0);
    check("reset_rd_addr_seen", 32'(bus.rd_addr_seen), 32'h0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].frame, vecs[v].nbits, vecs[v].hold, tx_seen);
      check("vec_rx_data", 32'(bus.rx_data), 32'(vecs[v].exp_data));
      check("vec_pulses", 32'(pulse_acc), 32'(vecs[v].exp_pulses));
      check("vec_rd_addr_seen", 32'(bus.rd_addr_seen), 32'(vecs[v].exp_rd));
      check("vec_tx_en_window", 32'(tx_seen), 32'(vecs[v].exp_tx));
      check("vec_tx_en_after_ss", 32'(bus.tx_en), 32'h0);
      $display("vec %0d: frame=%03h bits=%0d rx_data=%03h pulses=%0d rd=%0b tx=%0b",
               v, vecs[v].frame, vecs[v].nbits, bus.rx_data, pulse_acc,
               bus.rd_addr_seen, tx_seen);
    end

    // Async reset in the middle of a read-data frame.
    send_frame(10'h207, 10, 0, tx_seen);
    check("pre_reset_rd_addr_seen", 32'(bus.rd_addr_seen), 32'h1);
    bus.SS_n = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.MOSI = ((i % 2) == 0);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rx_data", 32'(bus.rx_data), 32'h0);
    check("async_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("async_tx_en", 32'(bus.tx_en), 32'h0);
    check("async_rd_addr_seen", 32'(bus.rd_addr_seen), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.SS_n = 1'b1;
    tick();
    send_frame(10'h0A5, 10, 0, tx_seen);
    check("post_reset_rx_data", 32'(bus.rx_data), 32'h0A5);
    check("post_reset_pulses", 32'(pulse_acc), 32'h1);
    $display("reset mid-frame: rx_data=%03h after recovery frame", bus.rx_data);

    // Random traffic: mostly-selected MOSI streams with occasional deselects.
    for (int n = 0; n < 600; n++) begin
      bus.SS_n = ($urandom_range(0, 11) == 0);
      bus.MOSI = 1'($urandom_range(0, 1));
      tick();
    end
    bus.SS_n = 1'b1;
    repeat (3) tick();
    $display("random phase: 600 cycles compared against reference model");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
